// File: rtl/ps2_pkg.sv
// PS/2 definitions shared by the host transmitter and the receiver: FSM encodings, frame
// length and the odd-parity helper.
package ps2_pkg;

   localparam int unsigned FrameLen = 11;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StXfer,
      StAck,
      StWaitIdle
   } ps2_tx_state_e;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus clock falling-edge detect.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_s_o,
   output logic data_s_o,
   output logic clk_fe_o
);

   logic [1:0] clk_sync_q;
   logic [1:0] data_sync_q;
   logic       clk_prev_q;

   // Idle bus is high, so everything resets to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[1];
      end
   end

   assign clk_s_o  = clk_sync_q[1];
   assign data_s_o = data_sync_q[1];
   assign clk_fe_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 device-clocked bits,
// ACK check, with a per-edge timeout. Both bus lines are open-drain (drive 0 or release).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_PROD    = 20,
   parameter int unsigned INHIBIT_CYC = 5000,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   inout  wire        ps2_clk,
   inout  wire        ps2_data
);

   localparam int unsigned CntMax = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYC - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

   if (CLK_PROD == 0) begin : g_bad_clk_prod
      $error("CLK_PROD must be non-zero");
   end

   ps2_tx_state_e   state_q;
   logic [7:0]      data_q;
   logic [3:0]      bit_q;
   logic [CntW-1:0] cnt_q;
   logic            clk_lo_q;
   logic            dat_lo_q;
   logic            ready_q;
   logic            done_q;
   logic            err_q;
   logic            ack_err_q;

   logic clk_s;
   logic data_s;
   logic clk_fe;
   logic tmo;

   ps2_sync_edge u_sync (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .clk_s_o    (clk_s),
      .data_s_o   (data_s),
      .clk_fe_o   (clk_fe)
   );

   assign tmo = (cnt_q == TimeoutLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         data_q    <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         clk_lo_q  <= 1'b0;
         dat_lo_q  <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tx_valid) begin
                  data_q   <= tx_data;
                  clk_lo_q <= 1'b1;
                  ready_q  <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= StInhibit;
               end
            end
            StInhibit: begin
               if (cnt_q == InhibitLast) begin
                  dat_lo_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= StRts;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StRts, StXfer, StAck, StWaitIdle: begin
               if (tmo && !clk_fe) begin
                  clk_lo_q <= 1'b0;
                  dat_lo_q <= 1'b0;
                  err_q    <= 1'b1;
                  ready_q  <= 1'b1;
                  state_q  <= StIdle;
               end else begin
                  // Count includes the fe cycle so a timeout lands TIMEOUT_CYC cycles after it.
                  cnt_q <= clk_fe ? CntW'(1) : cnt_q + 1'b1;
                  if (state_q == StRts) begin
                     clk_lo_q <= 1'b0;
                     bit_q    <= '0;
                     state_q  <= StXfer;
                  end else if (state_q == StXfer && clk_fe) begin
                     bit_q <= bit_q + 4'd1;
                     if (bit_q < 4'd8) begin
                        dat_lo_q <= ~data_q[bit_q[2:0]];
                     end else if (bit_q == 4'(FrameLen - 3)) begin
                        dat_lo_q <= ~odd_parity(data_q);
                     end else begin
                        dat_lo_q <= 1'b0;
                        state_q  <= StAck;
                     end
                  end else if (state_q == StAck && clk_fe) begin
                     ack_err_q <= data_s;
                     state_q   <= StWaitIdle;
                  end else if (state_q == StWaitIdle && clk_s && data_s) begin
                     done_q  <= ~ack_err_q;
                     err_q   <= ack_err_q;
                     ready_q <= 1'b1;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ps2_clk  = clk_lo_q ? 1'b0 : 1'bz;
   assign ps2_data = dat_lo_q ? 1'b0 : 1'bz;
   assign tx_ready = ready_q;
   assign tx_done  = done_q;
   assign tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the host while queued expected
// wire bits and outcomes are compared as they appear.
module tb_ps2_host_tx;

   localparam int unsigned ClkProd    = 20;
   localparam int unsigned InhibitCyc = 50;
   localparam int unsigned TimeoutCyc = 400;
   localparam int unsigned HalfBit    = 15;
   localparam int unsigned SyncLat    = 2;
   localparam logic [1:0]  ResNone    = 2'b00;
   localparam logic [1:0]  ResDone    = 2'b01;
   localparam logic [1:0]  ResErr     = 2'b10;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   wire        ps2_clk;
   wire        ps2_data;
   logic       dev_clk_lo = 1'b0;
   logic       dev_dat_lo = 1'b0;

   pullup (ps2_clk);
   pullup (ps2_data);
   assign ps2_clk  = dev_clk_lo ? 1'b0 : 1'bz;
   assign ps2_data = dev_dat_lo ? 1'b0 : 1'bz;

   int   n_chk       = 0;
   int   n_fail      = 0;
   int   done_seen   = 0;
   int   err_seen    = 0;
   int   cyc         = 0;
   int   last_fe_cyc = 0;
   logic both_hi     = 1'b0;
   logic       exp_bits[$];
   logic [1:0] exp_res[$];
   logic [7:0] b2b_seq[3] = '{8'h01, 8'h00, 8'hFF};

   ps2_host_tx #(
      .CLK_PROD    (ClkProd),
      .INHIBIT_CYC (InhibitCyc),
      .TIMEOUT_CYC (TimeoutCyc)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .tx_err   (tx_err),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data)
   );

   always #(ClkProd / 2) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_seen <= done_seen + 1;
      if (tx_err === 1'b1) err_seen <= err_seen + 1;
      if (tx_done === 1'b1 && tx_err === 1'b1) both_hi <= 1'b1;
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Request a frame: queue its expected wire bits and outcome, then follow the host through
   // inhibit and request-to-send up to the point where it releases ps2_clk.
   task automatic send_req(input logic [7:0] d, input logic [1:0] res);
      int k;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      exp_bits.push_back(~^d);
      exp_bits.push_back(1'b1);
      if (res != ResNone) exp_res.push_back(res);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      check_bit("req_clk_lo", ps2_clk, 1'b0);
      check_bit("req_ready_lo", tx_ready, 1'b0);
      check_bit("inhibit_dat_rel", ps2_data, 1'b1);
      k = 0;
      while (ps2_clk === 1'b0 && k < int'(InhibitCyc) + 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_int("clk_low_len", k, int'(InhibitCyc) + 1);
      check_bit("start_bit", ps2_data, exp_bits.pop_front());
   endtask

   // Device model: generate n_clk clock pulses, sampling the host's bit at each rising edge.
   task automatic dev_frame(input bit ack, input int n_clk);
      for (int i = 1; i <= n_clk; i++) begin
         if (i == 11 && ack) dev_dat_lo = 1'b1;
         repeat (HalfBit) @(negedge clk);
         dev_clk_lo  = 1'b1;
         last_fe_cyc = cyc;
         repeat (HalfBit) @(negedge clk);
         dev_clk_lo = 1'b0;
         if (i < 11) check_bit($sformatf("wire_bit%0d", i), ps2_data, exp_bits.pop_front());
      end
      dev_dat_lo = 1'b0;
   endtask

   task automatic check_result(output int at);
      int         k;
      int         d0;
      int         e0;
      logic [1:0] exp;
      exp = exp_res.pop_front();
      d0  = done_seen;
      e0  = err_seen;
      k   = 0;
      while (!(tx_done === 1'b1 || tx_err === 1'b1) && k < 4 * int'(TimeoutCyc)) begin
         @(posedge clk);
         #1;
         k++;
      end
      at = cyc;
      check_bit("done", tx_done, exp[0]);
      check_bit("err", tx_err, exp[1]);
      check_bit("clk_released", ps2_clk, 1'b1);
      check_bit("dat_released", ps2_data, 1'b1);
      @(posedge clk);
      #1;
      check_bit("done_one_cycle", tx_done, 1'b0);
      check_bit("err_one_cycle", tx_err, 1'b0);
      check_int("done_pulses", done_seen - d0, int'(exp[0]));
      check_int("err_pulses", err_seen - e0, int'(exp[1]));
      check_bit("ready_back", tx_ready, 1'b1);
   endtask

   initial begin
      int at;
      int d0;
      int e0;

      #1 reset = 1'b1;
      #1;
      check_bit("rst_ready", tx_ready, 1'b1);
      check_bit("rst_done", tx_done, 1'b0);
      check_bit("rst_err", tx_err, 1'b0);
      check_bit("rst_clk_rel", ps2_clk, 1'b1);
      check_bit("rst_dat_rel", ps2_data, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      send_req(8'hA5, ResDone);
      dev_frame(1'b1, 11);
      check_result(at);

      for (int i = 0; i < 3; i++) begin
         send_req(b2b_seq[i], ResDone);
         dev_frame(1'b1, 11);
         check_result(at);
      end

      send_req(8'h3C, ResErr);
      dev_frame(1'b0, 11);
      check_result(at);

      // Device stops after fe 4: the host must give up on its own.
      send_req(8'hC3, ResErr);
      dev_frame(1'b1, 4);
      exp_bits.delete();
      check_result(at);
      check_int("timeout_delay", at - last_fe_cyc, int'(TimeoutCyc + SyncLat));

      // Reset just after fe 6 while the host drives tx_data[5]=0.
      send_req(8'h0F, ResNone);
      dev_frame(1'b1, 6);
      exp_bits.delete();
      check_bit("pre_reset_dat_lo", ps2_data, 1'b0);
      d0 = done_seen;
      e0 = err_seen;
      #3 reset = 1'b1;
      #1;
      check_bit("mid_rst_dat_rel", ps2_data, 1'b1);
      check_bit("mid_rst_clk_rel", ps2_clk, 1'b1);
      check_bit("mid_rst_ready", tx_ready, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check_int("abort_no_done", done_seen - d0, 0);
      check_int("abort_no_err", err_seen - e0, 0);
      check_bit("abort_ready", tx_ready, 1'b1);
      send_req(8'h5A, ResDone);
      dev_frame(1'b1, 11);
      check_result(at);

      // tx_valid and tx_data churn during the transfer must not disturb the latched byte.
      send_req(8'h96, ResDone);
      fork
         dev_frame(1'b1, 11);
         begin
            for (int i = 0; i < 160; i++) begin
               @(negedge clk);
               tx_valid = ~tx_valid;
               tx_data  = 8'h69 ^ 8'(i);
            end
            tx_valid = 1'b0;
         end
      join
      check_result(at);

      check_bit("never_done_and_err", both_hi, 1'b0);
      check_int("scoreboard_empty", exp_res.size() + exp_bits.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #(ClkProd * 60000);
      $fatal(1, "FAIL watchdog: simulation exceeded %0d cycles", 60000);
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: CLK_PROD, default 20, system clock period in ns (simulation timing only).
REQ-002 Parameter: INHIBIT_CYC, default 5000, number of system cycles ps2_clk is held low (100 us at 50 MHz).
REQ-003 Parameter: TIMEOUT_CYC, default 100000, maximum number of system cycles allowed between device clock falling edges.
REQ-004 Port: clk  input  1  system clock; one clock domain only.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: tx_valid  input  1  host request to send a byte.
REQ-007 Port: tx_data  input  8  command byte to send to the device.
REQ-008 Port: tx_ready  output  1  module is idle and can accept a byte.
REQ-009 Port: tx_done  output  1  one-cycle pulse: frame sent and device ACK received.
REQ-010 Port: tx_err  output  1  one-cycle pulse: ACK missing or timeout.
REQ-011 Port: ps2_clk  inout  1  open-drain; the module only drives 0 or releases (Z).
REQ-012 Port: ps2_data  inout  1  open-drain; the module only drives 0 or releases (Z).

Function
REQ-013 ps2_clk SHALL pass through a 2-FF synchronizer, and a falling edge (fe) SHALL be detected on the synchronized value.
REQ-014 States SHALL be IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE.
REQ-015 IDLE: tx_ready=1 and both lines released. When tx_valid is high, tx_data SHALL be latched and the FSM SHALL go to INHIBIT on the next cycle.
REQ-016 INHIBIT: drive ps2_clk low, leave ps2_data released, for exactly INHIBIT_CYC cycles, then go to RTS.
REQ-017 RTS: drive ps2_data low (start bit) for 1 cycle with ps2_clk still low, then release ps2_clk and go to XFER.
REQ-018 XFER: bit counter 0..9. On each fe, drive the next bit (0 is driven low, 1 is released):
  - fe 1..8: tx_data[0]..tx_data[7], LSB first;
  - fe 9: odd parity, equal to ~^tx_data;
  - fe 10: release ps2_data (stop bit), then go to ACK.
REQ-019 ACK: on the next fe, sample synchronized ps2_data. If it is 0, go to WAIT_IDLE with a pending done; if it is 1, go to WAIT_IDLE with a pending err.
REQ-020 WAIT_IDLE: wait until synchronized ps2_clk and ps2_data are both 1, then pulse tx_done or tx_err for one cycle and return to IDLE.
REQ-021 Timeout counter: reset on every fe and on entry to RTS. In RTS, XFER, ACK and WAIT_IDLE, reaching TIMEOUT_CYC SHALL release both lines, pulse tx_err, and return to IDLE.
REQ-022 tx_valid outside IDLE SHALL be ignored, and tx_data SHALL NOT be re-latched mid-frame.
REQ-023 tx_done and tx_err SHALL never be high in the same cycle.
REQ-024 Latency: a tx_valid accepted at cycle N SHALL drive ps2_clk low at cycle N+1.

Reset
REQ-025 When reset is asserted, outputs SHALL take these values immediately, without waiting for a clock edge:
  - state=IDLE;
  - ps2_clk and ps2_data released;
  - tx_ready=1, tx_done=0, tx_err=0;
  - counters=0, synchronizers=1.
REQ-026 A reset mid-frame SHALL abort the frame with no tx_done or tx_err pulse.

Structure
REQ-027 ps2_pkg (shared with the receiver) SHALL hold the state encodings, the frame length constant 11, and the odd-parity function.
REQ-028 Clock synchronization and fe detection SHALL be one sub-module, ps2_sync_edge, reused by the PS2 receiver.
REQ-029 Total RTL SHALL be 120-400 lines, with no latches and no combinational path from tx_valid to tx_ready.

Verification
REQ-030 Send tx_data=8'hA5 with a device model that ACKs: wire bits 1,0,1,0,0,1,0,1, parity 1, stop 1; tx_done pulses once and tx_err stays 0.
REQ-031 Send 8'h01 (parity 0), 8'h00 (parity 1) and 8'hFF (parity 1) back to back: each frame matches bit-for-bit and each gives one tx_done.
REQ-032 Device withholds the ACK (data high at fe 11) for 8'h3C: tx_err pulses once and the bus is released.
REQ-033 Device stops clocking after fe 4: tx_err fires exactly TIMEOUT_CYC cycles after the last fe, and both lines return to Z.
REQ-034 Assert reset at fe 6: lines are released within the same time step, no done/err pulse occurs, tx_ready=1, and a following send of 8'h5A completes with tx_done.
REQ-035 Toggle tx_valid during XFER: the frame on the wire still matches the originally latched byte.
